// File: rtl/fm_phase_gen.sv
// fm_phase_gen: scales strobed audio into frequency deviation, integrates carrier+deviation into a 24-bit phase for a rotation-mode cordic.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   audio_in  : signed audio sample, qualified by stb_in
//   stb_in    : sample valid, may be high every cycle
//   mute      : zero the deviation of the strobed sample
//   phase_clr : clear the phase accumulator (applied one cycle later)
//   xo/yo/zo  : cordic x (constant amplitude), y (zero), z (phase)
//   stb_out   : one-cycle valid, two clocks after stb_in
module fm_phase_gen #(
  parameter logic [23:0] CARRIER_FCW = 24'h100000,
  parameter logic [15:0] KF          = 16'd256,
  parameter int          KF_SHIFT    = 8,
  parameter logic [15:0] AMPLITUDE   = 16'd19898
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_in,
  input  logic        stb_in,
  input  logic        mute,
  input  logic        phase_clr,
  output logic [15:0] xo,
  output logic [15:0] yo,
  output logic [23:0] zo,
  output logic        stb_out
);
  logic signed [32:0] w_prod;
  logic [23:0] w_dev, w_base, w_sum;
  logic [23:0] r_dev, r_acc, r_zo;
  logic [15:0] r_xo, r_yo;
  logic r_vld, r_clr, r_stb;
  assign w_prod = $signed({{17{audio_in[15]}}, audio_in}) * $signed({17'd0, KF});
  assign w_dev  = mute ? '0 : 24'(w_prod >>> KF_SHIFT);
  assign w_base = r_clr ? '0 : r_acc;
  assign w_sum  = w_base + CARRIER_FCW + r_dev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_dev <= '0;
      r_vld <= 1'b0;
      r_clr <= 1'b0;
    end else begin
      r_vld <= stb_in;
      r_clr <= phase_clr;
      if (stb_in) r_dev <= w_dev;
    end
  // A clear without a sample still resets the accumulator so the next sample starts from 0.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_acc <= '0;
      r_zo  <= '0;
      r_xo  <= '0;
      r_yo  <= '0;
      r_stb <= 1'b0;
    end else begin
      r_stb <= r_vld;
      if (r_vld) begin
        r_acc <= w_sum;
        r_zo  <= w_sum;
        r_xo  <= AMPLITUDE;
        r_yo  <= '0;
      end else if (r_clr) r_acc <= '0;
    end
  assign xo      = r_xo;
  assign yo      = r_yo;
  assign zo      = r_zo;
  assign stb_out = r_stb;
endmodule
